uart_tx_port: RTL and testbench

- Memory-mapped UART transmitter that sits on the CPU data bus beside the digital ports and Timer 0.
- Top-level decode maps it at 0xF2000000 (8 bytes) and muxes `dataOut` onto the bus read path.
- Bytes written by software enter an 8-deep FIFO. An FSM serialises them as 8N1 frames on `txd`, with a programmable bit period.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_port.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_port.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// STATUS bit positions and the bus base address.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_t;

  localparam int unsigned STAT_FULL  = 4;
  localparam int unsigned STAT_EMPTY = 5;
  localparam int unsigned STAT_BUSY  = 6;
  localparam int unsigned STAT_OVF   = 7;

  localparam logic [31:0] UART_BASE = 32'hF200_0000;

  // Top-level address decode helper: the block occupies an 8-byte window.
  function automatic logic uartHit(input logic [31:0] addr);
    return addr[31:3] == UART_BASE[31:3];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    doPop   = pop && !empty;
    doPush  = push && (!full || doPop);
    popData = mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: 8-deep TX FIFO feeding an 8N1 serialiser
// with programmable bit period. Define UART_TX_PARITY_EN for a parity bit.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'h0067
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipSelect,
  input  logic        regSelect,
  input  logic        write,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        txd
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned DIV_W = 17;
`else
  localparam int unsigned DIV_W = 16;
`endif
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  txState_t         state;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] baudCnt;
  logic [7:0]       shiftReg;
  logic [2:0]       bitIdx;
  logic             overflow;
`ifdef UART_TX_PARITY_EN
  logic             dataParity;
`endif

  logic             dataWr;
  logic             divWr;
  logic             bitEnd;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoHead;
  logic [CW-1:0]    fifoCount;
  logic [31:0]      status;
  logic             unusedBits;

  always_comb begin
    dataWr     = chipSelect && write && !regSelect;
    divWr      = chipSelect && write && regSelect;
    bitEnd     = (baudCnt == '0);
    // Pop from IDLE, or at the end of a stop bit to chain frames without a gap.
    fifoPop    = !fifoEmpty && ((state == ST_IDLE) || ((state == ST_STOP) && bitEnd));
    unusedBits = ^dataIn[31:DIV_W];
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) txFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (dataWr),
    .pop      (fifoPop),
    .pushData (dataIn[7:0]),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor  <= DIV_W'(DIV_RESET);
      overflow <= 1'b0;
    end else if (divWr) begin
      divisor  <= dataIn[DIV_W-1:0];
      overflow <= 1'b0;
    end else if (dataWr && fifoFull && !fifoPop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
`ifdef UART_TX_PARITY_EN
      dataParity <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifoPop) begin
            shiftReg <= fifoHead;
`ifdef UART_TX_PARITY_EN
            dataParity <= ^fifoHead;
`endif
            baudCnt  <= divisor;
            txd      <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bitEnd) begin
            txd      <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
            baudCnt  <= divisor;
            state    <= ST_DATA;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bitEnd) begin
            baudCnt <= divisor;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd   <= dataParity ^ divisor[16];
              state <= ST_PARITY;
`else
              txd   <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              txd      <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitIdx   <= bitIdx + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        ST_PARITY: begin
          if (bitEnd) begin
            txd     <= 1'b1;
            baudCnt <= divisor;
            state   <= ST_STOP;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bitEnd) begin
            if (fifoPop) begin
              shiftReg <= fifoHead;
`ifdef UART_TX_PARITY_EN
              dataParity <= ^fifoHead;
`endif
              baudCnt  <= divisor;
              txd      <= 1'b0;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    status              = '0;
    status[3:0]         = 4'(fifoCount);
    status[STAT_FULL]   = fifoFull;
    status[STAT_EMPTY]  = fifoEmpty;
    status[STAT_BUSY]   = (state != ST_IDLE);
    status[STAT_OVF]    = overflow;
  end

  always_comb begin
    if (!chipSelect)    dataOut = '0;
    else if (regSelect) dataOut = 32'(divisor);
    else                dataOut = status;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port; the parity frame step is
// exercised only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_port;

`ifdef UART_TX_PARITY_EN
  localparam bit          PAR      = 1'b1;
  localparam logic [31:0] DIV_MASK = 32'h0001_FFFF;
`else
  localparam bit          PAR      = 1'b0;
  localparam logic [31:0] DIV_MASK = 32'h0000_FFFF;
`endif
  localparam int unsigned FL = PAR ? 11 : 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipSelect;
  logic        regSelect;
  logic        write;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        txd;

  int nCmp = 0;
  int nMis = 0;

  logic txLog [0:127];

  uart_tx_port #(
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'h0067)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipSelect (chipSelect),
    .regSelect  (regSelect),
    .write      (write),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic frameBit(input logic [7:0] b, input int unsigned idx, input logic odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic sel, input logic [31:0] d);
    chipSelect = 1'b1;
    regSelect  = sel;
    write      = 1'b1;
    dataIn     = d;
    tick();
    write     = 1'b0;
    regSelect = 1'b0;
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic [31:0] exp);
    regSelect = 1'b0;
    #1;
    check(tag, dataOut, exp);
  endtask

  task automatic checkDiv(input string tag, input logic [31:0] exp);
    regSelect = 1'b1;
    #1;
    check(tag, dataOut, exp);
    regSelect = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zeros;
    int waited;
    reset = 1'b1; chipSelect = 1'b0; regSelect = 1'b0; write = 1'b0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset_txd", 32'(txd), 32'd1);
    check("nocs_read", dataOut, 32'h0);
    chipSelect = 1'b1;
    checkStatus("reset_status", 32'h20);
    checkDiv("reset_div", 32'h0067);

    // Single 0x55 frame at divisor 3
    busWrite(1'b1, 32'd3);
    checkDiv("div3", 32'd3);
    busWrite(1'b0, 32'h55);
    checkStatus("queued", 32'h01);
    check("pre_start_txd", 32'(txd), 32'd1);
    for (int s = 0; s < 4 * FL; s++) begin
      tick();
      check("f55_txd", 32'(txd), 32'(frameBit(8'h55, s / 4, 1'b0)));
      check("f55_busy", 32'(dataOut[6]), 32'd1);
    end
    tick();
    check("f55_done_status", dataOut, 32'h20);
    check("f55_done_txd", 32'(txd), 32'd1);

    // Ten consecutive pushes at divisor 0: overflow on the tenth
    busWrite(1'b1, 32'd0);
    chipSelect = 1'b1; regSelect = 1'b0; write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 32'(i);
      tick();
      txLog[i] = txd;
    end
    write = 1'b0;
    checkStatus("burst_full_ovf", 32'hD8);
    for (int j = 10; j <= 9 * FL; j++) begin
      tick();
      txLog[j] = txd;
    end
    check("burst_idle0", 32'(txLog[0]), 32'd1);
    for (int j = 1; j <= 9 * FL; j++) begin
      check("burst_stream", 32'(txLog[j]),
            32'(frameBit(8'((j - 1) / FL), (j - 1) % FL, 1'b0)));
    end
    tick();
    check("burst_done_status", dataOut, 32'hA0);
    check("burst_done_txd", 32'(txd), 32'd1);

    // Divisor write clears overflow; mid-frame change waits for the next bit boundary
    busWrite(1'b1, 32'd3);
    checkStatus("ovf_cleared_idle", 32'h20);
    chipSelect = 1'b1; regSelect = 1'b0; write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = (i == 0) ? 32'h55 : 32'(8'h10 + i);
      tick();
    end
    write = 1'b0;
    checkStatus("refill_ovf", 32'hD8);
    busWrite(1'b1, 32'd0);
    checkStatus("ovf_cleared_busy", 32'h58);
    check("middiv_bit1_a", 32'(txd), 32'(frameBit(8'h55, 2, 1'b0)));
    tick();
    check("middiv_bit1_b", 32'(txd), 32'(frameBit(8'h55, 2, 1'b0)));
    tick();
    check("middiv_bit1_c", 32'(txd), 32'(frameBit(8'h55, 2, 1'b0)));
    for (int idx = 3; idx < FL; idx++) begin
      tick();
      check("middiv_fast", 32'(txd), 32'(frameBit(8'h55, idx, 1'b0)));
    end
    tick();
    check("middiv_next_start", 32'(txd), 32'd0);
    waited = 0;
    while (dataOut != 32'h20 && waited < 300) begin
      tick();
      waited++;
    end
    check("drain_status", dataOut, 32'h20);

    // Reset in the middle of a 0 data bit of 0xA5, with a second byte queued
    busWrite(1'b1, 32'd3);
    busWrite(1'b0, 32'hA5);
    busWrite(1'b0, 32'h5A);
    repeat (8) tick();
    check("a5_bit1_low", 32'(txd), 32'd0);
    reset = 1'b1;
    tick();
    check("abort_txd", 32'(txd), 32'd1);
    reset = 1'b0;
    tick();
    checkStatus("abort_status", 32'h20);
    checkDiv("abort_div", 32'h0067);
    zeros = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (txd !== 1'b1) zeros++;
    end
    check("abort_no_residual", 32'(zeros), 32'd0);

    // Write strobe without chipSelect is ignored; dataIn[16] width boundary
    chipSelect = 1'b0; regSelect = 1'b1; write = 1'b1; dataIn = 32'd5;
    tick();
    write = 1'b0; chipSelect = 1'b1;
    checkDiv("nocs_write_ignored", 32'h0067);
    busWrite(1'b1, 32'h0001_0003);
    checkDiv("div_bit16", 32'h0001_0003 & DIV_MASK);

`ifdef UART_TX_PARITY_EN
    busWrite(1'b1, 32'h0001_0000);
    checkDiv("div_odd", 32'h0001_0000);
    busWrite(1'b0, 32'h03);
    check("par_pre_txd", 32'(txd), 32'd1);
    for (int idx = 0; idx < 11; idx++) begin
      tick();
      check("par_frame", 32'(txd), 32'(frameBit(8'h03, idx, 1'b1)));
    end
    tick();
    check("par_done_status", dataOut, 32'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
